rf_wb_arbiter: RTL

- Shares the register file's single write port between two writeback requesters: ALU result (alu_*) and memory load (mem_*).
- Uses round-robin arbitration with valid/ready handshakes and a one-entry registered output stage that drives the RF write port.
- Provides combinational read forwarding, so a write staged but not yet committed to the RF is visible on the read ports.
- Sits between the execute/memory stages and the 4x16 RF, and counts arbitration conflicts for performance debug.

---
 rtl/rf_wb_arbiter_if.sv | 28 ++
 rtl/rf_wb_arbiter.sv | 34 +++
 2 files changed

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: writeback requester, RF write port and read-forwarding signals.
interface rf_wb_arbiter_if #(parameter int WORD_SIZE = 16, parameter int ADDR_W = 2, parameter int CNT_W = 8);
  logic alu_valid, alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [WORD_SIZE-1:0] alu_data;
  logic mem_valid, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_data;
  logic rf_write;
  logic [ADDR_W-1:0] rf_write_register;
  logic [WORD_SIZE-1:0] rf_write_data;
  logic [ADDR_W-1:0] read_register1, read_register2;
  logic [WORD_SIZE-1:0] rf_read_data1, rf_read_data2;
  logic [WORD_SIZE-1:0] read_data1, read_data2;
  logic [CNT_W-1:0] conflict_cnt;
  modport slave (
    input alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
          read_register1, read_register2, rf_read_data1, rf_read_data2,
    output alu_ready, mem_ready, rf_write, rf_write_register, rf_write_data,
           read_data1, read_data2, conflict_cnt
  );
  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           read_register1, read_register2, rf_read_data1, rf_read_data2,
    input alu_ready, mem_ready, rf_write, rf_write_register, rf_write_data,
          read_data1, read_data2, conflict_cnt
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin ALU/load writeback arbiter with staged RF write and read forwarding.
module rf_wb_arbiter (
  input logic clk,
  input logic reset_n,
  rf_wb_arbiter_if.slave b
);
  logic ptr;
  logic both, alu_go, mem_go;
  // ptr high means the load side holds priority for the next conflict
  assign both = b.alu_valid & b.mem_valid;
  assign b.alu_ready = reset_n & ~(b.mem_valid & ptr);
  assign b.mem_ready = reset_n & ~(b.alu_valid & ~ptr);
  assign alu_go = b.alu_valid & b.alu_ready;
  assign mem_go = b.mem_valid & b.mem_ready;
  assign b.read_data1 = (b.rf_write && b.rf_write_register == b.read_register1) ? b.rf_write_data : b.rf_read_data1;
  assign b.read_data2 = (b.rf_write && b.rf_write_register == b.read_register2) ? b.rf_write_data : b.rf_read_data2;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= 1'b0;
      b.conflict_cnt <= '0;
      b.rf_write <= 1'b0;
      b.rf_write_register <= '0;
      b.rf_write_data <= '0;
    end else begin
      if (both) ptr <= ~ptr;
      if (both && b.conflict_cnt != '1) b.conflict_cnt <= b.conflict_cnt + 1'b1;
      b.rf_write <= alu_go | mem_go;
      if (alu_go | mem_go) begin
        b.rf_write_register <= alu_go ? b.alu_addr : b.mem_addr;
        b.rf_write_data <= alu_go ? b.alu_data : b.mem_data;
      end
    end
  end
endmodule
